logica_push_demux: RTL and testbench

Destination-side push logic for the transmission-layer arbiter path. Registers each word popped from the VC FIFOs, routes it to the D0 or D1 FIFO by its destination bit, and tracks each destination FIFO's occupancy. From that occupancy it generates the `D0_pause`/`D1_pause` back-pressure that the upstream pop logic consumes.

---
 rtl/logica_push_demux.sv | 113 +++++++++++
 tb/tb_logica_push_demux.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logica_push_demux.sv
// Destination push logic: registers popped VC words, routes them to D0/D1 by the MSB,
// tracks per-destination occupancy and drives hysteretic pause. Optional: PUSH_DROP_CNT_EN.
module logica_push_demux #(
    parameter int DATA_W  = 6,
    parameter int DEPTH   = 4,
    parameter int CNT_W   = 3,
    parameter int HIGH_TH = 3,
    parameter int LOW_TH  = 1
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              D0_pop,
    input  logic              D1_pop,
    output logic [DATA_W-1:0] data_out,
    output logic              D0_push,
    output logic              D1_push,
    output logic              D0_pause,
    output logic              D1_pause,
    output logic [CNT_W-1:0]  D0_cnt,
`ifdef PUSH_DROP_CNT_EN
    output logic [CNT_W-1:0]  D1_cnt,
    output logic [7:0]        drop_cnt
`else
    output logic [CNT_W-1:0]  D1_cnt
`endif
);

    typedef enum logic {RUN, HOLD} pause_state_t;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] HIGH_C  = CNT_W'(HIGH_TH);
    localparam logic [CNT_W-1:0] LOW_C   = CNT_W'(LOW_TH);

    logic                sel;
    logic [1:0]          pop;
    logic [1:0]          acc;
    logic [1:0]          pop_eff;
    logic [CNT_W-1:0]    cnt_q     [2];
    logic [CNT_W-1:0]    cnt_nxt   [2];
    pause_state_t        state_q   [2];
    pause_state_t        state_nxt [2];
    logic [1:0]          push_q;
    logic [DATA_W-1:0]   data_q;

    // A pop in the same cycle frees a slot, so a full destination still accepts.
    always_comb begin
        sel     = data_in[DATA_W-1];
        pop     = {D1_pop, D0_pop};
        acc     = '0;
        pop_eff = '0;
        for (int unsigned d = 0; d < 2; d++) begin
            acc[d[0]]     = valid_in && (sel == d[0]) &&
                            ((cnt_q[d[0]] < DEPTH_C) || pop[d[0]]);
            pop_eff[d[0]] = pop[d[0]] && (cnt_q[d[0]] != '0);

            cnt_nxt[d[0]] = cnt_q[d[0]];
            if (acc[d[0]] && !pop_eff[d[0]])
                cnt_nxt[d[0]] = cnt_q[d[0]] + 1'b1;
            else if (!acc[d[0]] && pop_eff[d[0]])
                cnt_nxt[d[0]] = cnt_q[d[0]] - 1'b1;

            state_nxt[d[0]] = state_q[d[0]];
            case (state_q[d[0]])
                RUN:  if (cnt_nxt[d[0]] >= HIGH_C) state_nxt[d[0]] = HOLD;
                HOLD: if (cnt_nxt[d[0]] <= LOW_C)  state_nxt[d[0]] = RUN;
                default: state_nxt[d[0]] = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_q <= '0;
            push_q <= '0;
            for (int unsigned d = 0; d < 2; d++) begin
                cnt_q[d]   <= '0;
                state_q[d] <= RUN;
            end
        end else begin
            push_q <= acc;
            if (|acc)
                data_q <= data_in;
            for (int unsigned d = 0; d < 2; d++) begin
                cnt_q[d]   <= cnt_nxt[d];
                state_q[d] <= state_nxt[d];
            end
        end
    end

    assign data_out = data_q;
    assign D0_push  = push_q[0];
    assign D1_push  = push_q[1];
    assign D0_cnt   = cnt_q[0];
    assign D1_cnt   = cnt_q[1];
    assign D0_pause = (state_q[0] == HOLD);
    assign D1_pause = (state_q[1] == HOLD);

`ifdef PUSH_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L)
            drop_q <= '0;
        else if (valid_in && !(|acc) && (drop_q != '1))
            drop_q <= drop_q + 8'd1;
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_logica_push_demux.sv
// Self-checking bench for logica_push_demux: directed scenarios plus randomized traffic
// against a behavioural occupancy/pause model.
module tb_logica_push_demux;

    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int CW    = 3;
    localparam int HI    = 3;
    localparam int LO    = 1;

    logic          clk      = 1'b0;
    logic          reset_L  = 1'b0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in  = '0;
    logic          D0_pop   = 1'b0;
    logic          D1_pop   = 1'b0;
    logic [DW-1:0] data_out;
    logic          D0_push, D1_push, D0_pause, D1_pause;
    logic [CW-1:0] D0_cnt, D1_cnt;
`ifdef PUSH_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    always #5 clk = ~clk;

    logica_push_demux #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .CNT_W  (CW),
        .HIGH_TH(HI),
        .LOW_TH (LO)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .valid_in(valid_in),
        .data_in (data_in),
        .D0_pop  (D0_pop),
        .D1_pop  (D1_pop),
        .data_out(data_out),
        .D0_push (D0_push),
        .D1_push (D1_push),
        .D0_pause(D0_pause),
        .D1_pause(D1_pause),
        .D0_cnt  (D0_cnt),
`ifdef PUSH_DROP_CNT_EN
        .D1_cnt  (D1_cnt),
        .drop_cnt(drop_cnt)
`else
        .D1_cnt  (D1_cnt)
`endif
    );

    int total = 0;
    int bad   = 0;

    int            m_cnt   [2];
    bit            m_pause [2];
    bit            m_push  [2];
    logic [DW-1:0] m_data;
    int            m_drop;

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_pause[k] = 1'b0; m_push[k] = 1'b0;
        end
        m_data = '0;
        m_drop = 0;
    endfunction

    function automatic void model_step(bit v, logic [DW-1:0] d, bit p0, bit p1);
        bit pop [2];
        int dst;
        bit accepted;
        int nxt;
        pop[0] = p0; pop[1] = p1;
        dst = d[DW-1] ? 1 : 0;
        accepted = v && (m_cnt[dst] < DEPTH || pop[dst]);
        for (int k = 0; k < 2; k++) begin
            nxt = m_cnt[k] + ((accepted && dst == k) ? 1 : 0)
                           - ((pop[k] && m_cnt[k] != 0) ? 1 : 0);
            if (!m_pause[k] && nxt >= HI)     m_pause[k] = 1'b1;
            else if (m_pause[k] && nxt <= LO) m_pause[k] = 1'b0;
            m_cnt[k]  = nxt;
            m_push[k] = accepted && (dst == k);
        end
        if (accepted) m_data = d;
        if (v && !accepted && m_drop < 255) m_drop++;
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] d, input bit p0, input bit p1);
        valid_in = v; data_in = d; D0_pop = p0; D1_pop = p1;
        @(posedge clk); #1;
        model_step(v, d, p0, p1);
        valid_in = 1'b0; D0_pop = 1'b0; D1_pop = 1'b0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #3;
        reset_L = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [DW+4+2*CW-1:0] obs;
        model_reset();
        #2;
        obs = {data_out, D0_push, D1_push, D0_pause, D1_pause, D0_cnt, D1_cnt};
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_state got=%h exp=0", obs);
        end
        @(posedge clk); #1;
        reset_L = 1'b1;
        step(1'b1, 6'b1_01010, 1'b0, 1'b0);
        valid_in = 1'b1; data_in = 6'b1_00001;
        #2;
        reset_L = 1'b0;
        #1;
        obs = {data_out, D0_push, D1_push, D0_pause, D1_pause, D0_cnt, D1_cnt};
        total++;
        if (obs !== '0) begin
            bad++; $display("FAIL reset_mid_traffic got=%h exp=0", obs);
        end
`ifdef PUSH_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'd0) begin
            bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt);
        end
`endif
        valid_in = 1'b0;
        reset_L = 1'b1;
        model_reset();
        step(1'b1, 6'b0_00101, 1'b0, 1'b0);
        total++;
        if ({D0_push, D1_push, data_out, D0_cnt} !== {1'b1, 1'b0, 6'd5, 3'd1}) begin
            bad++;
            $display("FAIL reset_first_word got push0=%b push1=%b data=%0d cnt0=%0d exp 1 0 5 1",
                     D0_push, D1_push, data_out, D0_cnt);
        end
    endtask

    task automatic test_routing();
        do_reset();
        step(1'b1, 6'b1_00011, 1'b0, 1'b0);
        total++;
        if ({D1_push, D0_push, data_out} !== {1'b1, 1'b0, 6'b1_00011}) begin
            bad++; $display("FAIL route_d1 got push1=%b push0=%b data=%h exp 1 0 23",
                            D1_push, D0_push, data_out);
        end
        step(1'b1, 6'b0_00111, 1'b0, 1'b0);
        total++;
        if ({D0_push, D1_push, data_out, D0_cnt, D1_cnt} !== {1'b1, 1'b0, 6'd7, 3'd1, 3'd1}) begin
            bad++; $display("FAIL route_d0 got push0=%b push1=%b data=%h cnt0=%0d cnt1=%0d exp 1 0 07 1 1",
                            D0_push, D1_push, data_out, D0_cnt, D1_cnt);
        end
        step(1'b0, 6'b0_00000, 1'b0, 1'b0);
        total++;
        if ({D0_push, D1_push, data_out} !== {1'b0, 1'b0, 6'd7}) begin
            bad++; $display("FAIL route_idle got push0=%b push1=%b data=%h exp 0 0 07",
                            D0_push, D1_push, data_out);
        end
    endtask

    task automatic test_hysteresis();
        do_reset();
        step(1'b1, 6'b0_00001, 1'b0, 1'b0);
        step(1'b1, 6'b0_00010, 1'b0, 1'b0);
        total++;
        if ({D0_cnt, D0_pause} !== {3'd2, 1'b0}) begin
            bad++; $display("FAIL hyst_cnt2 got cnt=%0d pause=%b exp 2 0", D0_cnt, D0_pause);
        end
        step(1'b1, 6'b0_00011, 1'b0, 1'b0);
        total++;
        if ({D0_cnt, D0_pause, D1_pause} !== {3'd3, 1'b1, 1'b0}) begin
            bad++; $display("FAIL hyst_rise got cnt=%0d pause0=%b pause1=%b exp 3 1 0",
                            D0_cnt, D0_pause, D1_pause);
        end
        step(1'b0, 6'b0, 1'b1, 1'b0);
        total++;
        if ({D0_cnt, D0_pause} !== {3'd2, 1'b1}) begin
            bad++; $display("FAIL hyst_hold got cnt=%0d pause=%b exp 2 1", D0_cnt, D0_pause);
        end
        step(1'b0, 6'b0, 1'b1, 1'b0);
        total++;
        if ({D0_cnt, D0_pause} !== {3'd1, 1'b0}) begin
            bad++; $display("FAIL hyst_fall got cnt=%0d pause=%b exp 1 0", D0_cnt, D0_pause);
        end
    endtask

    task automatic test_full_drop();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 6'(32 + i), 1'b0, 1'b0);
        total++;
        if ({D1_cnt, D1_pause} !== {3'd4, 1'b1}) begin
            bad++; $display("FAIL full_fill got cnt=%0d pause=%b exp 4 1", D1_cnt, D1_pause);
        end
        step(1'b1, 6'b1_11111, 1'b0, 1'b0);
        total++;
        if ({D1_push, D0_push, D1_cnt, data_out} !== {1'b0, 1'b0, 3'd4, 6'd35}) begin
            bad++; $display("FAIL full_reject got push1=%b push0=%b cnt=%0d data=%h exp 0 0 4 23",
                            D1_push, D0_push, D1_cnt, data_out);
        end
`ifdef PUSH_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'd1) begin
            bad++; $display("FAIL full_drop_cnt got=%0d exp=1", drop_cnt);
        end
`endif
        step(1'b1, 6'b1_10101, 1'b0, 1'b1);
        total++;
        if ({D1_push, D1_cnt, data_out} !== {1'b1, 3'd4, 6'b1_10101}) begin
            bad++; $display("FAIL full_pop_accept got push1=%b cnt=%0d data=%h exp 1 4 35",
                            D1_push, D1_cnt, data_out);
        end
    endtask

    task automatic test_empty_pop();
        do_reset();
        step(1'b0, 6'b0, 1'b1, 1'b1);
        total++;
        if ({D0_cnt, D1_cnt} !== {3'd0, 3'd0}) begin
            bad++; $display("FAIL empty_pop got cnt0=%0d cnt1=%0d exp 0 0", D0_cnt, D1_cnt);
        end
        step(1'b1, 6'b0_01000, 1'b1, 1'b0);
        total++;
        if ({D0_push, D0_cnt} !== {1'b1, 3'd1}) begin
            bad++; $display("FAIL empty_pop_accept got push=%b cnt=%0d exp 1 1", D0_push, D0_cnt);
        end
        step(1'b1, 6'b0_01001, 1'b0, 1'b0);
        step(1'b1, 6'b0_01010, 1'b1, 1'b0);
        total++;
        if ({D0_push, D0_cnt, D0_pause, data_out} !== {1'b1, 3'd2, 1'b0, 6'b0_01010}) begin
            bad++; $display("FAIL simul_acc_pop got push=%b cnt=%0d pause=%b data=%h exp 1 2 0 0a",
                            D0_push, D0_cnt, D0_pause, data_out);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 6'b1_00000, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, 6'(32 + (i % 32)), 1'b0, 1'b0);
        total++;
        if ({D1_push, D1_cnt} !== {1'b0, 3'd4}) begin
            bad++; $display("FAIL sat_full got push=%b cnt=%0d exp 0 4", D1_push, D1_cnt);
        end
`ifdef PUSH_DROP_CNT_EN
        total++;
        if (drop_cnt !== 8'd255) begin
            bad++; $display("FAIL sat_drop_cnt got=%0d exp=255", drop_cnt);
        end
`endif
    endtask

    task automatic test_random();
        logic [DW+4+2*CW-1:0] obs, exp;
        logic [DW-1:0] d;
        bit v, p0, p1;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                v  = ($urandom_range(0, 3) != 0);
                d  = DW'($urandom);
                p0 = ($urandom_range(0, 2) == 0);
                p1 = ($urandom_range(0, 2) == 0);
                step(v, d, p0, p1);
            end
            exp = {m_data, m_push[0], m_push[1], m_pause[0], m_pause[1],
                   CW'(m_cnt[0]), CW'(m_cnt[1])};
            obs = {data_out, D0_push, D1_push, D0_pause, D1_pause, D0_cnt, D1_cnt};
            total++;
            if (obs !== exp) begin
                bad++; $display("FAIL random_cycle%0d got=%h exp=%h", i, obs, exp);
            end
`ifdef PUSH_DROP_CNT_EN
            total++;
            if (drop_cnt !== 8'(m_drop)) begin
                bad++; $display("FAIL random_drop%0d got=%0d exp=%0d", i, drop_cnt, m_drop);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_hysteresis();
        test_full_drop();
        test_empty_pop();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
